dmem_line_responder: RTL and testbench
======================================

DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

Interface
REQ-001 Parameter LATENCY, default 10, meaning: cycles from request acceptance to ack (legal range 2..63).
REQ-002 Parameter LINE_BITS, default 9, meaning: log2 of the line count (default 512 lines of 256 bits).
REQ-003 Port clk_i  input  1  meaning: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  meaning: reset, asynchronous and active-low.
REQ-005 Port enable_i  input  1  meaning: request valid from the cache controller.
REQ-006 Port write_i  input  1  meaning: 1 = line write, 0 = line read; sampled with enable_i.
REQ-007 Port addr_i  input  32  meaning: byte address; bits [4:0] are ignored, and bits [LINE_BITS+4:5] select the line.
REQ-008 Port data_i  input  256  meaning: write line data.
REQ-009 Port ack_o  output  1  meaning: one-cycle completion pulse.
REQ-010 Port data_o  output  256  meaning: read line data, valid while ack_o=1 for a read.

Function
REQ-011 The block SHALL implement the states IDLE, BUSY and ACK.
REQ-012 In IDLE with enable_i=1, the block SHALL capture write_i, the line index and data_i, clear the counter, and move to BUSY at the next edge.
REQ-013 In IDLE with enable_i=0, the block SHALL remain in IDLE.
REQ-014 In BUSY, the counter SHALL increment by one per cycle; when it reaches LATENCY-2, the block SHALL move to ACK. ack_o therefore rises exactly LATENCY cycles after the edge that accepted the request.
REQ-015 On the BUSY->ACK edge, a captured write SHALL store the captured data into the captured line.
REQ-016 On the BUSY->ACK edge, a captured read SHALL load data_o from the captured line.
REQ-017 ack_o SHALL be 1 only in ACK, for exactly one cycle; ACK SHALL always move to IDLE at the next edge.
REQ-018 During BUSY and ACK, changes on enable_i, write_i, addr_i and data_i SHALL be ignored; an accepted request always completes, even if enable_i drops.
REQ-019 If enable_i is still 1 in the IDLE cycle after ACK, it SHALL be accepted as a new request, using the values present then. This supports a writeback followed directly by a fill without enable deasserting.
REQ-020 data_o SHALL hold its value between reads, and SHALL be unchanged by writes.
REQ-021 A read of a line written earlier SHALL return the last written 256-bit value.
REQ-022 Address bits above LINE_BITS+4 SHALL be ignored, so aliased addresses map to the same line.
REQ-023 The counter SHALL be 6 bits wide and SHALL never wrap, because the bound is checked before increment.

Reset
REQ-024 While rst_i=0: state=IDLE, counter=0, ack_o=0, data_o=0, captured request registers=0.
REQ-025 Reset mid-BUSY SHALL abandon the request: no array write occurs and no ack is issued.
REQ-026 The line array SHALL NOT be reset; its contents survive rst_i.
REQ-027 After rst_i rises, the first request SHALL be accepted only at a rising edge that samples rst_i=1.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2), LINE_W=256 and ADDR_W=32; the cache controller shall use the same package.
REQ-029 One sub-module, dmem_line_array, SHALL hold the storage: synchronous write, registered read, one port, no reset.
REQ-030 All control registers SHALL reside in dmem_line_responder.

Verification
REQ-031 Write then read: write line 0x1234_5678 repeated to addr 0x0000_0400, then read the same address -> ack_o at +10 cycles for each, and data_o equals the written line.
REQ-032 Back-to-back: write to 0x0000_0020 with enable_i held high, then addr switched to 0x0000_0040 (read) in the cycle after ack -> two acks 11 cycles apart; the read returns the prior content of line 2.
REQ-033 Enable drop: enable_i pulsed for 1 cycle for a read -> ack_o still asserts 10 cycles later, exactly once.
REQ-034 Input churn: addr_i and data_i changed every cycle during BUSY -> the array update and data_o reflect only the accepted values.
REQ-035 Reset mid-BUSY: rst_i=0 at cycle 5 of a write to line 7 -> no ack, and line 7 is unchanged on a later read.
REQ-036 Aliasing, with LINE_BITS=9: write to 0x0000_4000, then read 0x0000_0000 -> same data returned; LATENCY=2 run -> ack 2 cycles after acceptance.

Source files
------------

// File: rtl/dmem_line_responder_pkg.sv
// rtl/dmem_line_responder_pkg.sv - shared state encoding and widths for the line responder
package dmem_line_responder_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - single-port line storage, synchronous write, registered read, no reset
module dmem_line_array
    import dmem_line_responder_pkg::*;
#(
    parameter int LINE_BITS = 9
) (
    input  logic                 clk_i,
    input  logic [LINE_BITS-1:0] addr_i,
    input  logic                 we_i,
    input  logic [LINE_W-1:0]    wdata_i,
    input  logic                 re_i,
    output logic [LINE_W-1:0]    rdata_o
);

    logic [LINE_W-1:0] mem_q [2**LINE_BITS];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - fixed-latency 256-bit line memory responder for a cache controller
module dmem_line_responder
    import dmem_line_responder_pkg::*;
#(
    parameter int LATENCY   = 10,
    parameter int LINE_BITS = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam logic [5:0] CNT_LAST = 6'(LATENCY - 2);

    dmem_state_e          state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [LINE_BITS-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]    wdata_q, wdata_d;
    logic [LINE_W-1:0]    data_q, data_d;

    logic                 mem_we;
    logic                 mem_re;
    logic [LINE_BITS-1:0] mem_addr;
    logic [LINE_W-1:0]    mem_rdata;
    logic [LINE_BITS-1:0] req_line;
    logic                 unused_addr;

    assign req_line    = addr_i[LINE_BITS+4:5];
    assign unused_addr = ^{addr_i[ADDR_W-1:LINE_BITS+5], addr_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Reads are issued into the array's output register at acceptance, so even
    // LATENCY=2 has the line ready when BUSY hands over to ACK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    wr_d    = write_i;
                    idx_d   = req_line;
                    wdata_d = data_i;
                    cnt_d   = '0;
                    mem_re  = !write_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACK;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr = (state_q == ST_IDLE) ? req_line : idx_q;
    assign ack_o    = (state_q == ST_ACK);
    assign data_o   = data_q;

    dmem_line_array #(
        .LINE_BITS(LINE_BITS)
    ) u_array (
        .clk_i  (clk_i),
        .addr_i (mem_addr),
        .we_i   (mem_we),
        .wdata_i(wdata_q),
        .re_i   (mem_re),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - directed self-checking bench for dmem_line_responder
module tb_dmem_line_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack, ack2;
    logic [255:0] rdata, rdata2;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] PAT = {8{32'h1234_5678}};
    localparam logic [255:0] P1  = {8{32'hA5A5_0001}};
    localparam logic [255:0] P2  = {8{32'h0F0F_0002}};
    localparam logic [255:0] P3  = {8{32'h3C3C_0003}};
    localparam logic [255:0] P7  = {8{32'h7777_0007}};
    localparam logic [255:0] PX  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PA  = {8{32'hA11A_5000}};
    localparam logic [255:0] PB  = {8{32'hB0B0_0002}};

    always #5 clk = ~clk;

    dmem_line_responder #(.LATENCY(LAT), .LINE_BITS(9)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .enable_i(en),
        .write_i (wr),
        .addr_i  (addr),
        .data_i  (wdata),
        .ack_o   (ack),
        .data_o  (rdata)
    );

    dmem_line_responder #(.LATENCY(2), .LINE_BITS(9)) dut2 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .enable_i(en),
        .write_i (wr),
        .addr_i  (addr),
        .data_i  (wdata),
        .ack_o   (ack2),
        .data_o  (rdata2)
    );

    // Issues one request with a single-cycle enable pulse; lat counts edges from
    // the accepting edge (=1) to the edge after which ack is seen.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                           output int lat, output int extra);
        en = 1'b1; wr = w; addr = a; wdata = d;
        lat = -1; extra = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            en = 1'b0;
            if (ack) begin
                lat = i;
                break;
            end
        end
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            if (ack) extra++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++;
        if (rdata !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rdata); end
        checks++;
        if (ack2 !== 1'b0 || rdata2 !== '0) begin
            failures++; $display("FAIL reset_dut2 ack=%b data=%h exp=0/0", ack2, rdata2);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat, extra;
        run_req(1'b1, 32'h0000_0400, PAT, lat, extra);
        checks++;
        if (lat !== LAT || extra !== 0) begin
            failures++; $display("FAIL wr_latency got=%0d extra=%0d exp=%0d extra=0", lat, extra, LAT);
        end
        run_req(1'b0, 32'h0000_0400, '0, lat, extra);
        checks++;
        if (lat !== LAT || extra !== 0) begin
            failures++; $display("FAIL rd_latency got=%0d extra=%0d exp=%0d extra=0", lat, extra, LAT);
        end
        checks++;
        if (rdata !== PAT) begin failures++; $display("FAIL rd_data got=%h exp=%h", rdata, PAT); end
        run_req(1'b1, 32'h0000_0040, P2, lat, extra);
        run_req(1'b1, 32'h0000_00E0, P7, lat, extra);
        checks++;
        if (rdata !== PAT) begin failures++; $display("FAIL data_hold_on_write got=%h exp=%h", rdata, PAT); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, lat, extra;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0020; wdata = P1;
        a1 = -1; a2 = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                if (a1 < 0) begin
                    a1 = i;
                end else begin
                    a2 = i;
                    en = 1'b0;
                    break;
                end
            end else if (a1 >= 0 && i == a1 + 1) begin
                wr = 1'b0; addr = 32'h0000_0040;
            end
        end
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a1 < 0 || a2 < 0 || (a2 - a1) !== 11) begin
            failures++; $display("FAIL b2b_gap got=%0d (a1=%0d a2=%0d) exp=11", a2 - a1, a1, a2);
        end
        checks++;
        if (rdata !== P2) begin failures++; $display("FAIL b2b_read got=%h exp=%h", rdata, P2); end
        run_req(1'b0, 32'h0000_0020, '0, lat, extra);
        checks++;
        if (rdata !== P1) begin failures++; $display("FAIL b2b_write_stored got=%h exp=%h", rdata, P1); end
    endtask

    task automatic test_enable_drop();
        int lat, extra;
        run_req(1'b0, 32'h0000_00E0, '0, lat, extra);
        checks++;
        if (lat !== LAT || extra !== 0) begin
            failures++; $display("FAIL en_drop_ack got=%0d extra=%0d exp=%0d extra=0", lat, extra, LAT);
        end
        checks++;
        if (rdata !== P7) begin failures++; $display("FAIL en_drop_data got=%h exp=%h", rdata, P7); end
    endtask

    task automatic test_input_churn();
        int lat, extra, got;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdata = P3; got = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = i; en = 1'b0; break; end
            addr = $urandom; wdata = {8{$urandom}}; wr = 1'($urandom);
        end
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (got !== LAT) begin failures++; $display("FAIL churn_wr_ack got=%0d exp=%0d", got, LAT); end
        run_req(1'b0, 32'h0000_0060, '0, lat, extra);
        checks++;
        if (rdata !== P3) begin failures++; $display("FAIL churn_wr_line got=%h exp=%h", rdata, P3); end
        run_req(1'b0, 32'h0000_0040, '0, lat, extra);
        checks++;
        if (rdata !== P2) begin failures++; $display("FAIL churn_other_line got=%h exp=%h", rdata, P2); end
        en = 1'b1; wr = 1'b0; addr = 32'h0000_0400; wdata = '0; got = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = i; en = 1'b0; break; end
            addr = (i % 2 == 1) ? 32'h0000_0040 : $urandom; wdata = {8{$urandom}}; wr = 1'b0;
        end
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (got !== LAT || rdata !== PAT) begin
            failures++; $display("FAIL churn_read got=%h lat=%0d exp=%h lat=%0d", rdata, got, PAT, LAT);
        end
    endtask

    task automatic test_reset_busy();
        int lat, extra, nack;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00E0; wdata = PX;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || rdata !== '0) begin
            failures++; $display("FAIL rst_busy_outputs ack=%b data=%h exp=0/0", ack, rdata);
        end
        nack = 0;
        repeat (3) begin @(posedge clk); #1; if (ack) nack++; end
        rst_n = 1'b1;
        repeat (LAT + 2) begin @(posedge clk); #1; if (ack) nack++; end
        checks++;
        if (nack !== 0) begin failures++; $display("FAIL rst_busy_noack got=%0d exp=0", nack); end
        run_req(1'b0, 32'h0000_00E0, '0, lat, extra);
        checks++;
        if (rdata !== P7 || lat !== LAT) begin
            failures++; $display("FAIL rst_busy_line7 got=%h lat=%0d exp=%h lat=%0d", rdata, lat, P7, LAT);
        end
    endtask

    task automatic test_alias();
        int lat, extra;
        run_req(1'b1, 32'h0000_4000, PA, lat, extra);
        run_req(1'b0, 32'h0000_0000, '0, lat, extra);
        checks++;
        if (rdata !== PA || lat !== LAT) begin
            failures++; $display("FAIL alias_read got=%h lat=%0d exp=%h lat=%0d", rdata, lat, PA, LAT);
        end
    endtask

    task automatic test_latency2();
        int l_wr, l_rd;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0100; wdata = PB; l_wr = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            en = 1'b0;
            if (ack2) begin l_wr = i; break; end
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
        en = 1'b1; wr = 1'b0; addr = 32'h0000_0100; wdata = '0; l_rd = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            en = 1'b0;
            if (ack2) begin l_rd = i; break; end
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (l_wr !== 2 || l_rd !== 2) begin
            failures++; $display("FAIL lat2_ack got=%0d/%0d exp=2/2", l_wr, l_rd);
        end
        checks++;
        if (rdata2 !== PB) begin failures++; $display("FAIL lat2_data got=%h exp=%h", rdata2, PB); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_enable_drop();
        test_input_churn();
        test_reset_busy();
        test_alias();
        test_latency2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
